conv_out_streamer: RTL and testbench

Output-side companion to the `top_pe` 3x3 convolution PE. It accepts the PE's parallel 18-bit result vector of nine 2-bit outputs as a frame through a valid/ready handshake and buffers up to two frames. It then streams the results one element per beat, in row-major order, with row/column tags and an end-of-frame flag. It sits between `top_pe` and any serial consumer (checker, memory writer, off-chip link).

---
 rtl/conv_pkg.sv | 15 +
 rtl/frame_fifo.sv | 65 ++++++
 rtl/conv_out_streamer.sv | 142 ++++++++++++++
 tb/tb_conv_out_streamer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution output streamer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

   localparam int CONV_W    = 2;
   localparam int CONV_ROWS = 3;
   localparam int CONV_N    = CONV_ROWS * CONV_ROWS;

   typedef enum logic {
      S_IDLE,
      S_SEND
   } state_t;

endpackage

// File: rtl/frame_fifo.sv
// Generic DEPTH-entry register FIFO holding whole result frames.
// Latency: a pushed entry is visible at head_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; no full bypass.
//
// Ports: clk/rst_n; push + push_dat write the tail; pop retires the head;
//        head_dat is the current head entry; full/empty/count report occupancy.
module frame_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_dat = mem[head];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[tail] <= push_dat;
            tail      <= ptr_next(tail);
         end
         if (do_pop) begin
            head <= ptr_next(head);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/conv_out_streamer.sv
// Buffers PE result frames and streams them one element per beat, row-major.
// Latency: frame pushed into an empty block at edge t is presented after edge t+1.
// Backpressure: frame_ready from registered FIFO count; out_* held while out_ready low.
//
// Ports: frame_valid/frame_ready/frame_data  - parallel frame input handshake
//        out_valid/out_ready                 - per-element output handshake
//        out_data/out_row/out_col/out_last   - element value, position, end of frame
//        frame_cnt                           - frames fully streamed, mod 256
module conv_out_streamer
   import conv_pkg::*;
#(
   parameter int W     = CONV_W,
   parameter int ROWS  = CONV_ROWS,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   frame_valid,
   output logic                   frame_ready,
   input  logic [ROWS*ROWS*W-1:0] frame_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_data,
   output logic [1:0]             out_row,
   output logic [1:0]             out_col,
   output logic                   out_last,
   output logic [7:0]             frame_cnt
);

   localparam int N  = ROWS * ROWS;
   localparam int KW = $clog2(N);
   localparam int CW = $clog2(DEPTH + 1);

   state_t                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic [1:0]            row_q, row_d;
   logic [1:0]            col_q, col_d;
   logic [7:0]            cnt_q, cnt_d;

   logic [N*W-1:0]        head_dat;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CW-1:0]         fifo_count;
   logic                  push;
   logic                  pop;
   logic                  last_k;

   // Ready comes only from registered occupancy, so a final-beat pop in the
   // same cycle never opens a slot for a push.
   assign frame_ready = !fifo_full;
   assign push        = frame_valid && frame_ready;
   assign last_k      = (k_q == KW'(N - 1));
   assign pop         = (state_q == S_SEND) && out_ready && last_k;

   frame_fifo #(
      .WIDTH (N * W),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (frame_data),
      .pop      (pop),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // All out_* fields decode registered state only; out_ready never reaches them.
   assign out_valid = (state_q == S_SEND);
   assign out_data  = out_valid ? head_dat[k_q*W +: W] : '0;
   assign out_row   = row_q;
   assign out_col   = col_q;
   assign out_last  = out_valid && last_k;
   assign frame_cnt = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         row_q   <= row_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      row_d   = row_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_SEND;
               k_d     = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         S_SEND: begin
            if (out_ready) begin
               if (!last_k) begin
                  k_d = k_q + 1'b1;
                  // row/col track k directly instead of dividing k by ROWS
                  if (col_q == 2'(ROWS - 1)) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  k_d   = '0;
                  row_d = '0;
                  col_d = '0;
                  // Another frame remains if one was already queued behind the
                  // head, or one is being pushed on this very edge.
                  if ((fifo_count > CW'(1)) || push) begin
                     state_d = S_SEND;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_conv_out_streamer.sv
// Directed bench for conv_out_streamer: single frames, backpressure, full buffer,
// simultaneous push/pop, mid-frame reset and frame counter wrap.
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
module tb_conv_out_streamer;

   typedef int elems_t [9];

   logic        clk;
   logic        rst_n;
   logic        frame_valid;
   logic        frame_ready;
   logic [17:0] frame_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_data;
   logic [1:0]  out_row;
   logic [1:0]  out_col;
   logic        out_last;
   logic [7:0]  frame_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   conv_out_streamer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_data  (frame_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_last    (out_last),
      .frame_cnt   (frame_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [17:0] pk(input elems_t e);
      logic [17:0] r;
      r = '0;
      for (int i = 0; i < 9; i++) r[i*2 +: 2] = 2'(e[i]);
      return r;
   endfunction

   // {valid, data, row, col, last}
   function automatic logic [31:0] beat_exp(input elems_t e, input int i);
      return {24'd0, 1'b1, 2'(e[i]), 2'(i / 3), 2'(i % 3), (i == 8)};
   endfunction

   function automatic logic [31:0] beat_obs();
      return {24'd0, out_valid, out_data, out_row, out_col, out_last};
   endfunction

   task automatic push_one(input logic [17:0] f);
      frame_valid = 1'b1;
      frame_data  = f;
      tick();
      frame_valid = 1'b0;
   endtask

   task automatic expect_range(input string tag, input elems_t e, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         chk($sformatf("%s_beat%0d", tag, i), beat_obs(), beat_exp(e, i));
         tick();
      end
   endtask

   elems_t fa = '{1, 0, 0, 0, 1, 0, 0, 0, 2};
   // 18'h08141 decoded two bits at a time from bit 0 upward
   elems_t fb = '{1, 0, 0, 1, 1, 0, 0, 2, 0};
   elems_t fc = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
   elems_t fd = '{2, 2, 2, 1, 1, 1, 0, 0, 3};
   elems_t fe = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
   elems_t ff = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
   elems_t fg = '{1, 1, 0, 0, 2, 2, 3, 3, 1};
   elems_t fh = '{2, 0, 3, 1, 2, 0, 3, 1, 2};
   elems_t fi = '{3, 1, 3, 1, 3, 1, 3, 1, 3};
   elems_t fj = '{0, 3, 0, 3, 2, 3, 0, 3, 1};

   initial begin
      logic [3:0] pat;
      int         idx;

      rst_n       = 1'b1;
      frame_valid = 1'b0;
      frame_data  = '0;
      out_ready   = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_outputs", beat_obs(), 32'd0);
      chk("rst_frame_cnt", frame_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_frame_ready", frame_ready, 32'd1);

      // Single frame, element list form
      out_ready = 1'b1;
      push_one(pk(fa));
      chk("single_lat_idle", out_valid, 32'd0);
      tick();
      expect_range("single_a", fa, 0, 8);
      chk("single_a_done_valid", out_valid, 32'd0);
      chk("single_a_frame_cnt", frame_cnt, 32'd1);

      // Single frame, literal hex form
      push_one(18'h08141);
      tick();
      expect_range("single_b", fb, 0, 8);
      chk("single_b_frame_cnt", frame_cnt, 32'd2);

      // Backpressure with out_ready pattern 1,0,0,1 repeating
      pat = 4'b1001;
      push_one(pk(fc));
      tick();
      idx = 0;
      for (int c = 0; c < 40 && idx < 9; c++) begin
         out_ready = pat[c % 4];
         chk($sformatf("bp_cyc%0d_beat%0d", c, idx), beat_obs(), beat_exp(fc, idx));
         tick();
         if (out_ready) idx++;
      end
      out_ready = 1'b1;
      chk("bp_all_beats", idx, 32'd9);
      chk("bp_done_valid", out_valid, 32'd0);
      chk("bp_frame_cnt", frame_cnt, 32'd3);

      // Full buffer: third push must be refused
      out_ready = 1'b0;
      chk("full_rdy0", frame_ready, 32'd1);
      push_one(pk(fd));
      chk("full_rdy1", frame_ready, 32'd1);
      push_one(pk(fe));
      chk("full_rdy2", frame_ready, 32'd0);
      frame_valid = 1'b1;
      frame_data  = pk(ff);
      tick();
      tick();
      frame_valid = 1'b0;
      chk("full_rdy_still0", frame_ready, 32'd0);
      chk("full_head_held", beat_obs(), beat_exp(fd, 0));
      out_ready = 1'b1;
      expect_range("full_d", fd, 0, 7);
      chk("full_rdy_beat9", frame_ready, 32'd0);
      expect_range("full_d", fd, 8, 8);
      chk("full_rdy_back", frame_ready, 32'd1);
      expect_range("full_e", fe, 0, 8);
      chk("full_third_dropped", out_valid, 32'd0);
      tick();
      chk("full_third_dropped2", out_valid, 32'd0);
      chk("full_frame_cnt", frame_cnt, 32'd5);

      // Push on the cycle of the head frame's final beat
      push_one(pk(fg));
      tick();
      expect_range("simul_g", fg, 0, 7);
      frame_valid = 1'b1;
      frame_data  = pk(fh);
      expect_range("simul_g", fg, 8, 8);
      frame_valid = 1'b0;
      chk("simul_rdy_count1", frame_ready, 32'd1);
      expect_range("simul_h", fh, 0, 8);
      chk("simul_done_valid", out_valid, 32'd0);
      chk("simul_frame_cnt", frame_cnt, 32'd7);

      // Reset after four beats of a frame
      push_one(pk(fi));
      tick();
      expect_range("midrst_i", fi, 0, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_outputs", beat_obs(), 32'd0);
      chk("midrst_frame_cnt", frame_cnt, 32'd0);
      chk("midrst_frame_ready", frame_ready, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("midrst_after_valid", out_valid, 32'd0);
      push_one(pk(fj));
      tick();
      expect_range("midrst_j", fj, 0, 8);
      chk("midrst_frame_cnt1", frame_cnt, 32'd1);

      // Counter wrap: 254 more frames reach 255, one more wraps to 0
      for (int n = 0; n < 254; n++) begin
         push_one(pk(fa));
         repeat (10) tick();
      end
      chk("wrap_255", frame_cnt, 32'd255);
      chk("wrap_idle", out_valid, 32'd0);
      push_one(pk(fb));
      repeat (10) tick();
      chk("wrap_0", frame_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
